mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//  Initiator side of the unified instruction/data memory for the multi-cycle core.
//  Accepts one fetch/load/store request at a time and sequences it onto the
//  single-port memory (async read, posedge write). Sub-word stores are done as
//  read-modify-write; load results are sign- or zero-extended.
// PARAMETERS
//  MEM_WORDS  1000  words in the unified memory (0..499 instr, 500..999 data)
//  XLEN       32    data/address width
// PORTS
//  clk         in   1     clock
//  rst         in   1     reset, asynchronous, active-high
//  req_valid   in   1     request present
//  req_ready   out  1     controller idle, request accepted when valid&ready
//  req_addr    in   XLEN  byte address
//  req_we      in   1     1=store, 0=load/fetch
//  req_funct3  in   3     RV32I funct3 (fetch uses 3'b010)
//  req_wdata   in   XLEN  store data, data in low lanes
//  resp_valid  out  1     response present
//  resp_ready  in   1     response consumed when valid&ready
//  resp_rdata  out  XLEN  extended load data (0 for stores/errors)
//  resp_err    out  1     misaligned, out-of-range or illegal funct3
//  mem_A       out  XLEN  word-aligned address to memory
//  mem_WD      out  XLEN  write data to memory
//  mem_WE      out  1     write enable to memory
//  mem_RD      in   XLEN  read data from memory (combinational)
// BEHAVIOUR
//  States: IDLE, READ, WRITE, RESP, ERR. Reset -> IDLE; resp_valid=0, resp_err=0,
//   resp_rdata=0, mem_A=0, mem_WD=0, mem_WE=0.
//  req_ready=1 only in IDLE. mem_WE=1 only in WRITE, decoded from state register.
//  IDLE, on accept: latch addr, funct3, we, wdata; mem_A={addr[31:2],2'b00}.
//   Error if: funct3 011/110/111; store funct3 1xx; H misaligned (addr[0]);
//   W misaligned (addr[1:0]!=0); addr[31:2]>=MEM_WORDS -> ERR (no mem access).
//   Else load or SB/SH -> READ; SW -> WRITE.
//  READ (1 cycle): capture mem_RD into word register. Load -> RESP; SB/SH -> WRITE.
//  WRITE (1 cycle): mem_WE=1; SW: mem_WD=wdata; SB/SH: captured word with lane
//   addr[1:0] (byte) or addr[1] (half) replaced by wdata[7:0]/[15:0]. -> RESP.
//  RESP: resp_valid=1, resp_err=0. Load: lane extracted; B/H sign-extend, BU/HU
//   zero-extend, W raw. Store: resp_rdata=0. Hold until resp_ready -> IDLE.
//  ERR: resp_valid=1, resp_err=1, resp_rdata=0; hold until resp_ready -> IDLE.
//  Latency from accept edge: load 2 cycles, SW 2, SB/SH 3, error 1 to resp_valid.
//  resp_* stable while resp_valid&!resp_ready. No new accept before RESP/ERR exits
//   (next accept earliest the cycle after resp handshake).
//  Exactly one mem_WE pulse per successful store; none for loads/errors.
//  rst mid-operation: immediate return to IDLE, mem_WE drops same cycle, pending
//   write discarded, no response issued.
// STRUCTURE
//  Package riscv_mem_pkg: funct3 constants (F3_B/H/W/BU/HU), state enum
//   localparams, MEM_WORDS default.
//  Sub-module mem_lane_align (combinational): store-lane merge and load-lane
//   extract/extend; instantiated once.
// TESTING (memory preloaded word 500 (0x7D0)=0x8CDEFAB7)
//  1 LW 0x7D0 -> resp_valid 2 cycles after accept, rdata 0x8CDEFAB7, err 0.
//  2 LB 0x7D1 -> 0xFFFFFFFA; LBU 0x7D1 -> 0x000000FA; LH 0x7D2 -> 0xFFFF8CDE;
//    LHU 0x7D2 -> 0x00008CDE.
//  3 SB 0x7D3 wdata 0x12345611 -> one WE pulse in cycle 2, word 500=0x11DEFAB7,
//    resp cycle 3; SW 0x7D0 wdata 0xDEADBEEF -> WE cycle 1, word=0xDEADBEEF.
//  4 SH 0x7D1, LW 0xFA0, funct3 3'b011 -> resp_err=1 next cycle, no WE pulse.
//  5 resp_ready low 5 cycles on LW -> resp_valid/rdata stable, req_ready=0;
//    then back-to-back LW requests accepted one cycle after each handshake.
//  6 rst asserted during WRITE of SW 0x7D0 -> mem_WE=0 same cycle, word unchanged,
//    resp_valid=0, req_ready=1 after release.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// Shared constants and types for the memory access controller.
// Holds funct3 encodings, the controller state type and the default memory depth.
package riscv_mem_pkg;

  localparam int MEM_WORDS_DEF = 1000;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_RESP,
    ST_ERR
  } state_t;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request/response handshake plus the single-port memory bus of the controller.
// The master modport is the core/memory side; the slave modport is the controller.
interface mem_access_ctrl_if #(parameter int XLEN = 32);

  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_addr;
  logic            req_we;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_wdata;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_rdata;
  logic            resp_err;
  logic [XLEN-1:0] mem_A;
  logic [XLEN-1:0] mem_WD;
  logic            mem_WE;
  logic [XLEN-1:0] mem_RD;

  modport master (
    output req_valid, req_addr, req_we, req_funct3, req_wdata, resp_ready, mem_RD,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_A, mem_WD, mem_WE
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_funct3, req_wdata, resp_ready, mem_RD,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_A, mem_WD, mem_WE
  );

endinterface

// File: rtl/mem_lane_align.sv
// Combinational lane handling: merges a byte/half into a read word for sub-word
// stores, and extracts/extends the addressed lane of a loaded word.
module mem_lane_align
  import riscv_mem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      byte_off,
  input  logic [15:0]     wdata,
  input  logic [XLEN-1:0] old_word,
  input  logic [XLEN-1:0] rd_word,
  output logic [XLEN-1:0] merged,
  output logic [XLEN-1:0] rdata_ext
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    merged = old_word;
    case (funct3[1:0])
      2'b00:   merged[{byte_off, 3'b000} +: 8]     = wdata[7:0];
      2'b01:   merged[{byte_off[1], 4'b0000} +: 16] = wdata;
      default: merged = old_word;
    endcase
  end

  always_comb begin
    byte_v    = rd_word[{byte_off, 3'b000} +: 8];
    half_v    = rd_word[{byte_off[1], 4'b0000} +: 16];
    rdata_ext = rd_word;
    case (funct3)
      F3_B:    rdata_ext = {{(XLEN-8){byte_v[7]}}, byte_v};
      F3_H:    rdata_ext = {{(XLEN-16){half_v[15]}}, half_v};
      F3_BU:   rdata_ext = {{(XLEN-8){1'b0}}, byte_v};
      F3_HU:   rdata_ext = {{(XLEN-16){1'b0}}, half_v};
      default: rdata_ext = rd_word;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Initiator for the unified instruction/data memory: one request at a time,
// sub-word stores as read-modify-write, load data extended per funct3.
module mem_access_ctrl
  import riscv_mem_pkg::*;
#(
  parameter int MEM_WORDS = MEM_WORDS_DEF,
  parameter int XLEN      = 32
) (
  input  logic               clk,
  input  logic               rst,
  mem_access_ctrl_if.slave   bus
);

  state_t          state_q, state_d;
  logic [1:0]      addr_lo_q;
  logic [2:0]      f3_q;
  logic            we_q;
  logic [15:0]     wdata_lo_q;
  logic [XLEN-1:0] word_q;
  logic [XLEN-1:0] mem_a_q;
  logic [XLEN-1:0] mem_wd_q;
  logic [XLEN-1:0] word_idx;
  logic [XLEN-1:0] merged;
  logic [XLEN-1:0] rdata_ext;
  logic            accept;
  logic            req_err;

  assign accept   = bus.req_valid && (state_q == ST_IDLE);
  assign word_idx = {2'b00, bus.req_addr[XLEN-1:2]};

  always_comb begin
    req_err = 1'b0;
    if (bus.req_funct3 == 3'b011 || bus.req_funct3[2:1] == 2'b11) req_err = 1'b1;
    if (bus.req_we && bus.req_funct3[2])                           req_err = 1'b1;
    if (bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0])           req_err = 1'b1;
    if (bus.req_funct3 == F3_W && bus.req_addr[1:0] != 2'b00)       req_err = 1'b1;
    if (word_idx >= XLEN'(MEM_WORDS))                               req_err = 1'b1;
  end

  mem_lane_align #(.XLEN(XLEN)) u_lane (
    .funct3    (f3_q),
    .byte_off  (addr_lo_q),
    .wdata     (wdata_lo_q),
    .old_word  (bus.mem_RD),
    .rd_word   (word_q),
    .merged    (merged),
    .rdata_ext (rdata_ext)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_lo_q  <= '0;
      f3_q       <= '0;
      we_q       <= 1'b0;
      wdata_lo_q <= '0;
      word_q     <= '0;
      mem_a_q    <= '0;
      mem_wd_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_lo_q  <= bus.req_addr[1:0];
        f3_q       <= bus.req_funct3;
        we_q       <= bus.req_we;
        wdata_lo_q <= bus.req_wdata[15:0];
        if (!req_err) begin
          mem_a_q <= {bus.req_addr[XLEN-1:2], 2'b00};
          if (bus.req_we) mem_wd_q <= bus.req_wdata;
        end
      end
      // Sub-word stores build their write word from the word read this cycle.
      if (state_q == ST_READ) begin
        word_q <= bus.mem_RD;
        if (we_q) mem_wd_q <= merged;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_err   = 1'b0;
    bus.resp_rdata = '0;
    bus.mem_WE     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        bus.req_ready = 1'b1;
        if (accept) begin
          if (req_err)                                  state_d = ST_ERR;
          else if (bus.req_we && bus.req_funct3 == F3_W) state_d = ST_WRITE;
          else                                          state_d = ST_READ;
        end
      end
      ST_READ:  state_d = we_q ? ST_WRITE : ST_RESP;
      ST_WRITE: begin
        bus.mem_WE = 1'b1;
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        bus.resp_valid = 1'b1;
        if (!we_q) bus.resp_rdata = rdata_ext;
        if (bus.resp_ready) state_d = ST_IDLE;
      end
      ST_ERR: begin
        bus.resp_valid = 1'b1;
        bus.resp_err   = 1'b1;
        if (bus.resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.mem_A  = mem_a_q;
  assign bus.mem_WD = mem_wd_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural 1000-word memory.
module tb_mem_access_ctrl;
  import riscv_mem_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic preload;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mem_access_ctrl_if #(.XLEN(32)) bus ();

  mem_access_ctrl #(.MEM_WORDS(1000), .XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] mem [0:999];
  int          mem_idx;

  always_comb begin
    mem_idx    = int'(bus.mem_A[31:2]);
    bus.mem_RD = (mem_idx < 1000) ? mem[mem_idx] : 32'h0;
  end

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 1000; i++) mem[i] <= 32'h0;
      mem[500] <= 32'h8CDEFAB7;
    end else if (bus.mem_WE && mem_idx < 1000) begin
      mem[mem_idx] <= bus.mem_WD;
    end
  end

  task automatic issue(input logic [31:0] a, input logic we, input logic [2:0] f3,
                       input logic [31:0] wd, output int lat, output int wecyc,
                       output int pulses, output logic [31:0] rdata, output logic err);
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_addr   = a;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_wdata  = wd;
    @(posedge clk);
    lat = 0; wecyc = 0; pulses = 0;
    do begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      lat++;
      if (bus.mem_WE) begin pulses++; wecyc = lat; end
    end while (!bus.resp_valid && lat < 10);
    rdata = bus.resp_rdata;
    err   = bus.resp_err;
    if (!bus.resp_valid) begin
      $display("FAIL timeout addr=%h: resp_valid never seen within %0d cycles", a, lat);
      errors++;
      checks++;
    end
  endtask

  task automatic finish_resp();
    bus.resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; preload = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    preload = 1'b0;
    if (bus.resp_valid !== 1'b0) begin $display("FAIL reset_resp_valid got %b want 0", bus.resp_valid); errors++; end
    checks++;
    if (bus.resp_err !== 1'b0) begin $display("FAIL reset_resp_err got %b want 0", bus.resp_err); errors++; end
    checks++;
    if (bus.resp_rdata !== 32'h0) begin $display("FAIL reset_resp_rdata got %h want 0", bus.resp_rdata); errors++; end
    checks++;
    if (bus.mem_A !== 32'h0 || bus.mem_WD !== 32'h0 || bus.mem_WE !== 1'b0) begin
      $display("FAIL reset_mem_bus got A=%h WD=%h WE=%b want all 0", bus.mem_A, bus.mem_WD, bus.mem_WE); errors++;
    end
    checks++;
    rst = 1'b0;
    @(negedge clk);
    if (bus.req_ready !== 1'b1) begin $display("FAIL reset_req_ready got %b want 1", bus.req_ready); errors++; end
    checks++;
  endtask

  task automatic test_load_word();
    int lat, wecyc, pulses; logic [31:0] rd; logic err;
    issue(32'h7D0, 1'b0, F3_W, 32'h0, lat, wecyc, pulses, rd, err);
    if (lat !== 2) begin $display("FAIL lw_latency got %0d want 2", lat); errors++; end
    checks++;
    if (rd !== 32'h8CDEFAB7 || err !== 1'b0) begin
      $display("FAIL lw_data got %h err=%b want 8cdefab7 err=0", rd, err); errors++;
    end
    checks++;
    if (pulses !== 0) begin $display("FAIL lw_no_we got %0d pulses want 0", pulses); errors++; end
    checks++;
    finish_resp();
  endtask

  task automatic test_load_ext();
    logic [31:0] t_addr [4] = '{32'h7D1, 32'h7D1, 32'h7D2, 32'h7D2};
    logic [2:0]  t_f3   [4] = '{F3_B, F3_BU, F3_H, F3_HU};
    logic [31:0] t_exp  [4] = '{32'hFFFFFFFA, 32'h000000FA, 32'hFFFF8CDE, 32'h00008CDE};
    int lat, wecyc, pulses; logic [31:0] rd; logic err;
    for (int i = 0; i < 4; i++) begin
      issue(t_addr[i], 1'b0, t_f3[i], 32'h0, lat, wecyc, pulses, rd, err);
      if (rd !== t_exp[i] || err !== 1'b0 || lat !== 2) begin
        $display("FAIL load_ext[%0d] got %h err=%b lat=%0d want %h err=0 lat=2", i, rd, err, lat, t_exp[i]);
        errors++;
      end
      checks++;
      finish_resp();
    end
  endtask

  task automatic test_store();
    int lat, wecyc, pulses; logic [31:0] rd; logic err;
    issue(32'h7D3, 1'b1, F3_B, 32'h12345611, lat, wecyc, pulses, rd, err);
    if (lat !== 3 || wecyc !== 2 || pulses !== 1) begin
      $display("FAIL sb_timing got lat=%0d we_cycle=%0d pulses=%0d want 3/2/1", lat, wecyc, pulses); errors++;
    end
    checks++;
    if (rd !== 32'h0 || err !== 1'b0) begin $display("FAIL sb_resp got %h err=%b want 0 err=0", rd, err); errors++; end
    checks++;
    finish_resp();
    if (mem[500] !== 32'h11DEFAB7) begin $display("FAIL sb_word got %h want 11defab7", mem[500]); errors++; end
    checks++;
    issue(32'h7D0, 1'b1, F3_W, 32'hDEADBEEF, lat, wecyc, pulses, rd, err);
    if (lat !== 2 || wecyc !== 1 || pulses !== 1) begin
      $display("FAIL sw_timing got lat=%0d we_cycle=%0d pulses=%0d want 2/1/1", lat, wecyc, pulses); errors++;
    end
    checks++;
    finish_resp();
    if (mem[500] !== 32'hDEADBEEF) begin $display("FAIL sw_word got %h want deadbeef", mem[500]); errors++; end
    checks++;
  endtask

  task automatic test_errors();
    logic [31:0] t_addr [3] = '{32'h7D1, 32'hFA0, 32'h7D0};
    logic        t_we   [3] = '{1'b1, 1'b0, 1'b0};
    logic [2:0]  t_f3   [3] = '{F3_H, F3_W, 3'b011};
    int lat, wecyc, pulses; logic [31:0] rd; logic err;
    for (int i = 0; i < 3; i++) begin
      issue(t_addr[i], t_we[i], t_f3[i], 32'hA5A5A5A5, lat, wecyc, pulses, rd, err);
      if (err !== 1'b1 || lat !== 1 || pulses !== 0 || rd !== 32'h0) begin
        $display("FAIL err_case[%0d] got err=%b lat=%0d pulses=%0d rdata=%h want 1/1/0/0", i, err, lat, pulses, rd);
        errors++;
      end
      checks++;
      finish_resp();
    end
    if (mem[500] !== 32'hDEADBEEF) begin $display("FAIL err_no_write got %h want deadbeef", mem[500]); errors++; end
    checks++;
  endtask

  task automatic test_back_to_back();
    int lat, wecyc, pulses; logic [31:0] rd; logic err;
    issue(32'h7D0, 1'b0, F3_W, 32'h0, lat, wecyc, pulses, rd, err);
    if (rd !== 32'hDEADBEEF) begin $display("FAIL hold_first got %h want deadbeef", rd); errors++; end
    checks++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'hDEADBEEF || bus.req_ready !== 1'b0) begin
        $display("FAIL hold_stable[%0d] got valid=%b rdata=%h req_ready=%b want 1/deadbeef/0",
                 i, bus.resp_valid, bus.resp_rdata, bus.req_ready);
        errors++;
      end
      checks++;
    end
    bus.resp_ready = 1'b1;
    bus.req_valid  = 1'b1;
    bus.req_addr   = 32'h7D1;
    bus.req_we     = 1'b0;
    bus.req_funct3 = F3_B;
    @(posedge clk);
    @(negedge clk);
    bus.resp_ready = 1'b0;
    if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      $display("FAIL b2b_idle got resp_valid=%b req_ready=%b want 0/1", bus.resp_valid, bus.req_ready); errors++;
    end
    checks++;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    if (bus.req_ready !== 1'b0) begin $display("FAIL b2b_accept got req_ready=%b want 0", bus.req_ready); errors++; end
    checks++;
    @(posedge clk);
    @(negedge clk);
    if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'hFFFFFFBE) begin
      $display("FAIL b2b_second got valid=%b rdata=%h want 1/ffffffbe", bus.resp_valid, bus.resp_rdata); errors++;
    end
    checks++;
    finish_resp();
  endtask

  task automatic test_reset_mid_write();
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_addr   = 32'h7D0;
    bus.req_we     = 1'b1;
    bus.req_funct3 = F3_W;
    bus.req_wdata  = 32'h55555555;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    if (bus.mem_WE !== 1'b1) begin $display("FAIL rst_pre_we got %b want 1", bus.mem_WE); errors++; end
    checks++;
    #1 rst = 1'b1;
    #1;
    if (bus.mem_WE !== 1'b0 || bus.resp_valid !== 1'b0) begin
      $display("FAIL rst_we_drop got WE=%b resp_valid=%b want 0/0", bus.mem_WE, bus.resp_valid); errors++;
    end
    checks++;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    if (mem[500] !== 32'hDEADBEEF) begin $display("FAIL rst_word got %h want deadbeef", mem[500]); errors++; end
    checks++;
    for (int i = 0; i < 3; i++) begin
      if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
        $display("FAIL rst_idle[%0d] got resp_valid=%b req_ready=%b want 0/1", i, bus.resp_valid, bus.req_ready);
        errors++;
      end
      checks++;
      @(negedge clk);
    end
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_addr   = 32'h0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_wdata  = 32'h0;
    bus.resp_ready = 1'b0;
    test_reset();
    test_load_word();
    test_load_ext();
    test_store();
    test_errors();
    test_back_to_back();
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
